// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between N_REQ byte producers.
// Optional `UART_ARB_TAG_EN: a TAG_BASE+index byte precedes every change of channel.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned START_TIMEOUT = 16,
  parameter logic [7:0]  TAG_BASE      = 8'h30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic               err_to
);

  localparam int unsigned   PW     = $clog2(N_REQ);
  localparam int unsigned   CW     = $clog2(START_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(START_TIMEOUT);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_DONE, S_TAG_START, S_TAG_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE} state_t;
`endif

  state_t           r_state, w_state;
  logic [PW-1:0]    r_rr_ptr, w_rr_ptr;
  logic [CW-1:0]    r_cnt, w_cnt, w_cnt_inc;
  logic [N_REQ-1:0] r_req_ack, w_req_ack;
  logic [N_REQ-1:0] r_grant, w_grant;
  logic             r_tx_start, w_tx_start;
  logic             r_err_to, w_err_to;
  logic [7:0]       r_tx_data, w_tx_data;
`ifdef UART_ARB_TAG_EN
  logic [7:0]       r_byte, w_byte;
  logic [PW-1:0]    r_cur, w_cur;
  logic [PW-1:0]    r_last_ch, w_last_ch;
  logic             r_last_vld, w_last_vld;
`endif

  logic [7:0]       w_bytes [N_REQ];
  logic             w_found;
  logic             w_timeout;
  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_scan;
  logic [N_REQ-1:0] w_win_oh;

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[8*g +: 8];
  end

  // First pending requester at or after rr_ptr, wrapping past N_REQ-1 to 0.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_scan  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_scan = PW'((32'(r_rr_ptr) + i) % N_REQ);
      if (!w_found && req_valid[w_scan]) begin
        w_found = 1'b1;
        w_win   = w_scan;
      end
    end
  end

  assign w_win_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
  assign w_cnt_inc = (r_cnt == TO_VAL) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout = (w_cnt_inc == TO_VAL);

  always_comb begin
    w_state    = r_state;
    w_rr_ptr   = r_rr_ptr;
    w_cnt      = '0;
    w_req_ack  = '0;
    w_grant    = r_grant;
    w_tx_start = r_tx_start;
    w_tx_data  = r_tx_data;
    w_err_to   = 1'b0;
`ifdef UART_ARB_TAG_EN
    w_byte     = r_byte;
    w_cur      = r_cur;
    w_last_ch  = r_last_ch;
    w_last_vld = r_last_vld;
`endif
    case (r_state)
      S_IDLE: begin
        if (!tx_busy && w_found) begin
          w_req_ack  = w_win_oh;
          w_grant    = w_win_oh;
          w_rr_ptr   = PW'((32'(w_win) + 32'd1) % N_REQ);
          w_tx_start = 1'b1;
          w_tx_data  = w_bytes[w_win];
          w_state    = S_START;
`ifdef UART_ARB_TAG_EN
          w_cur  = w_win;
          w_byte = w_bytes[w_win];
          if (!r_last_vld || r_last_ch != w_win) begin
            w_tx_data = TAG_BASE + 8'(w_win);
            w_state   = S_TAG_START;
          end
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      S_START, S_TAG_START: begin
`else
      S_START: begin
`endif
        w_cnt = w_cnt_inc;
        if (tx_busy) begin
          w_tx_start = 1'b0;
          w_state    = S_WAIT_DONE;
`ifdef UART_ARB_TAG_EN
          if (r_state == S_TAG_START) w_state = S_TAG_DONE;
`endif
        end else if (w_timeout) begin
          // A timed-out tag abandons the latched data byte as well.
          w_tx_start = 1'b0;
          w_err_to   = 1'b1;
          w_grant    = '0;
          w_state    = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          w_grant = '0;
          w_state = S_IDLE;
`ifdef UART_ARB_TAG_EN
          w_last_ch  = r_cur;
          w_last_vld = 1'b1;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      S_TAG_DONE: begin
        if (!tx_busy) begin
          w_tx_data  = r_byte;
          w_tx_start = 1'b1;
          w_state    = S_START;
        end
      end
`endif
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_req_ack  <= '0;
      r_grant    <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_err_to   <= 1'b0;
`ifdef UART_ARB_TAG_EN
      r_byte     <= '0;
      r_cur      <= '0;
      r_last_ch  <= '0;
      r_last_vld <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_rr_ptr   <= w_rr_ptr;
      r_cnt      <= w_cnt;
      r_req_ack  <= w_req_ack;
      r_grant    <= w_grant;
      r_tx_start <= w_tx_start;
      r_tx_data  <= w_tx_data;
      r_err_to   <= w_err_to;
`ifdef UART_ARB_TAG_EN
      r_byte     <= w_byte;
      r_cur      <= w_cur;
      r_last_ch  <= w_last_ch;
      r_last_vld <= w_last_vld;
`endif
    end
  end

  assign req_ack  = r_req_ack;
  assign grant    = r_grant;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign err_to   = r_err_to;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed steps plus randomized rounds checked against
// a rotating-priority model and a byte log captured by a simple uart_tx stand-in.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 16;
  localparam logic [7:0] TAGB = 8'h30;
  localparam int UM_NORMAL = 0;
  localparam int UM_NOBUSY = 1;
  localparam int UM_FORCE  = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   grant;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           err_to;

  uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(T), .TAG_BASE(TAGB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .err_to(err_to)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int n_err_seen = 0;
  int um_mode = UM_FORCE;
  int um_dly = 2;
  int um_len = 4;
  logic um_force = 1'b0;
  logic [7:0] wire_q [$];
  logic [7:0] rq_bytes [N];
  int m_ptr = 0;
`ifdef UART_ARB_TAG_EN
  int   m_last = 0;
  logic m_last_vld = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // uart_tx stand-in: busy rises um_dly cycles after tx_start is seen, lasts um_len cycles.
  initial begin : uart_model
    int ph;
    int cnt;
    ph = 0;
    cnt = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (um_mode == UM_FORCE) begin
        tx_busy = um_force;
        ph = 0;
      end else if (ph == 0) begin
        if (tx_start === 1'b1 && um_mode == UM_NORMAL) begin
          ph = 1;
          cnt = um_dly;
        end
      end else if (ph == 1) begin
        cnt--;
        if (cnt == 0) begin
          tx_busy = 1'b1;
          wire_q.push_back(tx_data);
          ph = 2;
          cnt = um_len;
        end
      end else begin
        cnt--;
        if (cnt == 0) begin
          tx_busy = 1'b0;
          ph = 0;
        end
      end
    end
  end

  always @(negedge clk) if (err_to === 1'b1) n_err_seen <= n_err_seen + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    um_mode = UM_FORCE;
    um_force = 1'b0;
    rst = 1'b1;
    req_valid = '0;
    repeat (3) tick();
    chk("reset_outputs", 32'({req_ack, grant, tx_start, tx_data, err_to}), 32'd0);
    rst = 1'b0;
    um_mode = UM_NORMAL;
    m_ptr = 0;
`ifdef UART_ARB_TAG_EN
    m_last_vld = 1'b0;
`endif
  endtask

  task automatic wait_idle(input int n);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      tick();
      if (grant == '0 && wire_q.size() >= n) ok = 1'b1;
    end
    chk("idle_wait", 32'(ok), 32'd1);
  endtask

  // All requesters in mask present at once; the model predicts service order and wire bytes.
  task automatic run_round(input logic [N-1:0] mask);
    int ord [$];
    logic [7:0] exp_w [$];
    int base;
    int errs0;
    int last;
    logic got;
    base = wire_q.size();
    errs0 = n_err_seen;
    last = 0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (mask[idx]) begin
        ord.push_back(idx);
`ifdef UART_ARB_TAG_EN
        if (!m_last_vld || m_last != idx) exp_w.push_back(TAGB + 8'(idx));
        m_last = idx;
        m_last_vld = 1'b1;
`endif
        exp_w.push_back(rq_bytes[idx]);
        last = idx;
      end
    end
    m_ptr = (last + 1) % N;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = rq_bytes[i];
    req_valid = mask;
    foreach (ord[j]) begin
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
        tick();
        if (req_ack != '0) got = 1'b1;
      end
      chk("ack_wait", 32'(got), 32'd1);
      if (got) begin
        chk("ack_index", 32'(req_ack), 32'(onehot(ord[j])));
        chk("ack_grant", 32'(grant), 32'(onehot(ord[j])));
        chk("ack_start", 32'(tx_start), 32'd1);
        req_valid = req_valid & ~req_ack;
      end
    end
    req_valid = '0;
    wait_idle(base + exp_w.size());
    chk("wire_count", 32'(wire_q.size() - base), 32'(exp_w.size()));
    foreach (exp_w[j]) begin
      if (base + j < wire_q.size()) chk("wire_byte", 32'(wire_q[base + j]), 32'(exp_w[j]));
    end
    chk("no_err_to", 32'(n_err_seen - errs0), 32'd0);
  endtask

  initial begin : main
    int base;
    int n_hi;
    logic [N-1:0] acc;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    do_reset();

`ifndef UART_ARB_TAG_EN
    // single byte, exact handshake timing
    do_reset();
    base = wire_q.size();
    um_dly = 2;
    um_len = 100;
    req_data[7:0] = 8'h41;
    req_valid = 4'b0001;
    tick();
    chk("t1_ack", 32'(req_ack), 32'h1);
    chk("t1_start", 32'(tx_start), 32'd1);
    chk("t1_data", 32'(tx_data), 32'h41);
    chk("t1_grant", 32'(grant), 32'h1);
    req_valid = '0;
    tick();
    chk("t1_ack_pulse", 32'(req_ack), 32'h0);
    chk("t1_start_hold", 32'(tx_start), 32'd1);
    tick();
    chk("t1_start_busy_cycle", 32'(tx_start), 32'd1);
    tick();
    chk("t1_start_fall", 32'(tx_start), 32'd0);
    chk("t1_grant_hold", 32'(grant), 32'h1);
    repeat (99) tick();
    chk("t1_grant_busy_end", 32'(grant), 32'h1);
    tick();
    chk("t1_grant_clear", 32'(grant), 32'h0);
    chk("t1_wire_n", 32'(wire_q.size() - base), 32'd1);
    if (wire_q.size() > base) chk("t1_wire", 32'(wire_q[base]), 32'h41);
`endif

    // two simultaneous requesters, twice: pointer wraps back to req0
    do_reset();
    um_dly = 3;
    um_len = 5;
    rq_bytes[0] = 8'h11; rq_bytes[1] = 8'h00; rq_bytes[2] = 8'h22; rq_bytes[3] = 8'h00;
    run_round(4'b0101);
    run_round(4'b0101);

`ifndef UART_ARB_TAG_EN
    // start timeout with busy never rising
    do_reset();
    um_mode = UM_NOBUSY;
    req_data[15:8] = 8'h5A;
    req_valid = 4'b0010;
    tick();
    chk("t3_ack", 32'(req_ack), 32'h2);
    req_valid = '0;
    n_hi = 1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (tx_start === 1'b1) n_hi++;
      else break;
    end
    chk("t3_start_cycles", 32'(n_hi), 32'(T));
    chk("t3_err_pulse", 32'(err_to), 32'd1);
    chk("t3_grant_clear", 32'(grant), 32'h0);
    tick();
    chk("t3_err_one_cycle", 32'(err_to), 32'd0);
    um_mode = UM_NORMAL;
    m_ptr = 2;
    rq_bytes[0] = 8'h60; rq_bytes[1] = 8'h61;
    run_round(4'b0011);

    // reset three cycles into START, request still held
    do_reset();
    um_mode = UM_NOBUSY;
    req_data[31:24] = 8'h77;
    req_valid = 4'b1000;
    tick();
    chk("t4_ack", 32'(req_ack), 32'h8);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t4_reset_outputs", 32'({req_ack, grant, tx_start, tx_data, err_to}), 32'd0);
    rst = 1'b0;
    um_mode = UM_NORMAL;
    base = wire_q.size();
    tick();
    chk("t4_fresh_ack", 32'(req_ack), 32'h8);
    chk("t4_start", 32'(tx_start), 32'd1);
    req_valid = '0;
    wait_idle(base + 1);
    if (wire_q.size() > base) chk("t4_wire", 32'(wire_q[base]), 32'h77);

    // busy held high blocks capture until it falls
    do_reset();
    um_mode = UM_FORCE;
    um_force = 1'b1;
    tick();
    req_data[31:24] = 8'h3C;
    req_valid = 4'b1000;
    acc = '0;
    repeat (6) begin
      tick();
      acc = acc | req_ack;
    end
    chk("t5_no_ack_while_busy", 32'(acc), 32'h0);
    base = wire_q.size();
    um_force = 1'b0;
    tick();
    chk("t5_no_ack_busy_fall", 32'(req_ack), 32'h0);
    um_mode = UM_NORMAL;
    tick();
    chk("t5_ack", 32'(req_ack), 32'h8);
    req_valid = '0;
    wait_idle(base + 1);
    if (wire_q.size() > base) chk("t5_wire", 32'(wire_q[base]), 32'h3C);
`else
    // channel tags on the wire
    begin
      logic [7:0] t6 [5];
      do_reset();
      um_dly = 2;
      um_len = 3;
      base = wire_q.size();
      rq_bytes[1] = 8'hAA;
      run_round(4'b0010);
      rq_bytes[1] = 8'hBB;
      run_round(4'b0010);
      rq_bytes[2] = 8'hCC;
      run_round(4'b0100);
      t6[0] = 8'h31; t6[1] = 8'hAA; t6[2] = 8'hBB; t6[3] = 8'h32; t6[4] = 8'hCC;
      chk("t6_wire_n", 32'(wire_q.size() - base), 32'd5);
      for (int j = 0; j < 5; j++)
        if (base + j < wire_q.size()) chk("t6_wire", 32'(wire_q[base + j]), 32'(t6[j]));
    end
`endif

    // randomized rounds
    do_reset();
    for (int r = 0; r < 30; r++) begin
      um_dly = $urandom_range(1, 6);
      um_len = $urandom_range(1, 12);
      for (int i = 0; i < N; i++) rq_bytes[i] = 8'($urandom);
      run_round(N'($urandom_range(1, (1 << N) - 1)));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
